// File: rtl/pipe_control_unit.sv
// Pipelined control unit. It decodes the instruction in ID and resolves
// branches and jumps there. The control word is registered into ID/EX.
// Mult/div occupy EX for several cycles under a busy counter. HALT is
// sticky until reset.
module pipe_control_unit #(
  parameter int OP_WIDTH      = 4,
  parameter int FUNC_WIDTH    = 4,
  parameter int ALU_OP_WIDTH  = 3,
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_WIDTH     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  input  logic [OP_WIDTH-1:0]     opcode,
  input  logic [FUNC_WIDTH-1:0]   funct_code,
  input  logic                    cmp_lt,
  input  logic                    cmp_gt,
  input  logic                    cmp_eq,
  input  logic                    load_use_hazard,
  output logic                    pc_src,
  output logic                    if_flush,
  output logic                    pc_stall,
  output logic                    ex_valid,
  output logic [1:0]              ex_byte_access,
  output logic [1:0]              ex_write_back,
  output logic                    ex_mem_write,
  output logic                    ex_mem_read,
  output logic [1:0]              ex_alu_src,
  output logic [ALU_OP_WIDTH-1:0] ex_alu_op,
  output logic                    ex_we1,
  output logic                    ex_we2,
  output logic                    ex_wd2,
  output logic                    muldiv_busy,
  output logic                    halted,
  output logic                    illegal_op
);

  typedef struct packed {
    logic                    valid;
    logic [1:0]              byte_access;
    logic [1:0]              write_back;
    logic                    mem_write;
    logic                    mem_read;
    logic [1:0]              alu_src;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic                    we1;
    logic                    we2;
    logic                    wd2;
  } ctrl_t;

  typedef enum logic [1:0] {S_RUN, S_MD_WAIT, S_HALT} state_t;

  localparam logic [ALU_OP_WIDTH-1:0] A_AND = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] A_OR  = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] A_ADD = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] A_SUB = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] A_MUL = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] A_DIV = ALU_OP_WIDTH'(5);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  ctrl_t                ex_q, ex_d, dec;
  logic                 busy_q, busy_d, halted_q, halted_d, ill_q, ill_d;
  logic                 is_ill, is_br, br_taken, is_jmp, is_md, is_halt;

  // Combinational decode of the ID instruction into a control word
  always_comb begin
    dec      = '0;
    is_ill   = 1'b0;
    is_br    = 1'b0;
    br_taken = 1'b0;
    is_jmp   = 1'b0;
    is_md    = 1'b0;
    is_halt  = 1'b0;
    case (opcode)
      OP_WIDTH'(0): begin
        dec.valid      = 1'b1;
        dec.write_back = 2'b10;
        dec.we1        = 1'b1;
        case (funct_code)
          FUNC_WIDTH'(0):  dec.alu_op = A_ADD;
          FUNC_WIDTH'(1):  dec.alu_op = A_SUB;
          FUNC_WIDTH'(4):  begin dec.alu_op = A_MUL; is_md = 1'b1; end
          FUNC_WIDTH'(8):  begin dec.alu_op = A_DIV; is_md = 1'b1; end
          FUNC_WIDTH'(14): dec.alu_op = A_ADD;
          FUNC_WIDTH'(15): begin dec.alu_op = A_ADD; dec.we2 = 1'b1; dec.wd2 = 1'b1; end
          default: begin dec = '0; is_ill = 1'b1; end
        endcase
      end
      OP_WIDTH'(1), OP_WIDTH'(2): begin
        dec.valid      = 1'b1;
        dec.write_back = 2'b10;
        dec.alu_src    = 2'b01;
        dec.alu_op     = (opcode == OP_WIDTH'(1)) ? A_AND : A_OR;
        dec.we1        = 1'b1;
      end
      OP_WIDTH'(8), OP_WIDTH'(10): begin
        dec.valid       = 1'b1;
        dec.byte_access = (opcode == OP_WIDTH'(8)) ? 2'b10 : 2'b00;
        dec.write_back  = (opcode == OP_WIDTH'(8)) ? 2'b00 : 2'b01;
        dec.mem_read    = 1'b1;
        dec.alu_src     = 2'b10;
        dec.alu_op      = A_ADD;
        dec.we1         = 1'b1;
      end
      OP_WIDTH'(9), OP_WIDTH'(11): begin
        dec.valid       = 1'b1;
        dec.byte_access = (opcode == OP_WIDTH'(9)) ? 2'b01 : 2'b00;
        dec.mem_write   = 1'b1;
        dec.alu_src     = 2'b10;
        dec.alu_op      = A_ADD;
      end
      OP_WIDTH'(4):  begin is_br = 1'b1; br_taken = cmp_lt; end
      OP_WIDTH'(5):  begin is_br = 1'b1; br_taken = cmp_gt; end
      OP_WIDTH'(6):  begin is_br = 1'b1; br_taken = cmp_eq; end
      OP_WIDTH'(12): is_jmp  = 1'b1;
      OP_WIDTH'(15): is_halt = 1'b1;
      default:       is_ill  = 1'b1;
    endcase
  end

  // Next state, ID/EX word and PC control; the priority order is HALT, then mult/div wait, then hazard, then decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ex_d     = '0;
    busy_d   = 1'b0;
    ill_d    = 1'b0;
    pc_src   = 1'b0;
    if_flush = 1'b0;
    pc_stall = 1'b0;
    case (state_q)
      S_RUN: begin
        if (load_use_hazard) begin
          pc_stall = 1'b1;
        end else if (instr_valid) begin
          if (is_halt) begin
            state_d = S_HALT;
          end else if (is_ill) begin
            ill_d = 1'b1;
          end else if (is_br || is_jmp) begin
            pc_src   = is_jmp | br_taken;
            if_flush = is_jmp | br_taken;
          end else begin
            ex_d = dec;
            if (is_md) begin
              busy_d = 1'b1;
              if (MULDIV_CYCLES > 1) begin
                // Results are written back only on the last EX cycle.
                ex_d.we1 = 1'b0;
                state_d  = S_MD_WAIT;
                cnt_d    = CNT_WIDTH'(MULDIV_CYCLES - 2);
              end
            end
          end
        end
      end
      S_MD_WAIT: begin
        pc_stall   = 1'b1;
        busy_d     = 1'b1;
        ex_d       = ex_q;
        ex_d.valid = 1'b0;
        ex_d.we1   = (cnt_q == '0);
        ex_d.we2   = 1'b0;
        ex_d.wd2   = 1'b0;
        if (cnt_q == '0) state_d = S_RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_HALT:  pc_stall = 1'b1;
      default: state_d  = S_RUN;
    endcase
    halted_d = (state_d == S_HALT);
  end

  // State, counter and ID/EX pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RUN;
      cnt_q    <= '0;
      ex_q     <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ex_q     <= ex_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      ill_q    <= ill_d;
    end
  end

  assign ex_valid       = ex_q.valid;
  assign ex_byte_access = ex_q.byte_access;
  assign ex_write_back  = ex_q.write_back;
  assign ex_mem_write   = ex_q.mem_write;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_alu_src     = ex_q.alu_src;
  assign ex_alu_op      = ex_q.alu_op;
  assign ex_we1         = ex_q.we1;
  assign ex_we2         = ex_q.we2;
  assign ex_wd2         = ex_q.wd2;
  assign muldiv_busy    = busy_q;
  assign halted         = halted_q;
  assign illegal_op     = ill_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Testbench for pipe_control_unit. Each step drives one ID instruction
// and checks the comb PC controls. The expected registered word is
// queued and compared after the next rising edge.
module tb_pipe_control_unit;
  logic clk = 1'b0, rst = 1'b1, instr_valid = 1'b0;
  logic [3:0] opcode = '0, funct_code = '0;
  logic cmp_lt = 1'b0, cmp_gt = 1'b0, cmp_eq = 1'b0, load_use_hazard = 1'b0;
  logic pc_src, if_flush, pc_stall, ex_valid, ex_mem_write, ex_mem_read;
  logic [1:0] ex_byte_access, ex_write_back, ex_alu_src;
  logic [2:0] ex_alu_op;
  logic ex_we1, ex_we2, ex_wd2, muldiv_busy, halted, illegal_op;

  int checks = 0, failures = 0;

  typedef struct { string tag; logic [17:0] r; } exp_t;
  exp_t sb[$];

  // Field order: valid_ba_wb_mw_mr_as_op_{we1,we2,wd2}_{busy,halted,illegal}
  localparam logic [17:0] E0    = 18'b0;
  localparam logic [17:0] ADDW  = 18'b1_00_10_0_0_00_010_100_000;
  localparam logic [17:0] SUBW  = 18'b1_00_10_0_0_00_011_100_000;
  localparam logic [17:0] MUL_I = 18'b1_00_10_0_0_00_100_000_100;
  localparam logic [17:0] MUL_W = 18'b0_00_10_0_0_00_100_000_100;
  localparam logic [17:0] MUL_F = 18'b0_00_10_0_0_00_100_100_100;
  localparam logic [17:0] DIV_I = 18'b1_00_10_0_0_00_101_000_100;
  localparam logic [17:0] DIV_W = 18'b0_00_10_0_0_00_101_000_100;
  localparam logic [17:0] DIV_F = 18'b0_00_10_0_0_00_101_100_100;
  localparam logic [17:0] ILL   = 18'b0_00_00_0_0_00_000_000_001;
  localparam logic [17:0] LWW   = 18'b1_00_01_0_1_10_010_100_000;
  localparam logic [17:0] LBW   = 18'b1_10_00_0_1_10_010_100_000;
  localparam logic [17:0] SBW   = 18'b1_01_00_1_0_10_010_000_000;
  localparam logic [17:0] SWW   = 18'b1_00_00_1_0_10_010_000_000;
  localparam logic [17:0] ANDIW = 18'b1_00_10_0_0_01_000_100_000;
  localparam logic [17:0] ORIW  = 18'b1_00_10_0_0_01_001_100_000;
  localparam logic [17:0] SWAPW = 18'b1_00_10_0_0_00_010_111_000;
  localparam logic [17:0] HLT   = 18'b0_00_00_0_0_00_000_000_010;

  pipe_control_unit dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
    .funct_code(funct_code), .cmp_lt(cmp_lt), .cmp_gt(cmp_gt), .cmp_eq(cmp_eq),
    .load_use_hazard(load_use_hazard), .pc_src(pc_src), .if_flush(if_flush),
    .pc_stall(pc_stall), .ex_valid(ex_valid), .ex_byte_access(ex_byte_access),
    .ex_write_back(ex_write_back), .ex_mem_write(ex_mem_write),
    .ex_mem_read(ex_mem_read), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_we1(ex_we1), .ex_we2(ex_we2), .ex_wd2(ex_wd2),
    .muldiv_busy(muldiv_busy), .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // rs: reset, v: instr_valid, fl: {lt,gt,eq}, c: {pc_src,if_flush,pc_stall}
  task automatic step(input string tag, input logic rs, input logic v,
                      input logic [3:0] op, input logic [3:0] fn,
                      input logic [2:0] fl, input logic hz,
                      input logic [2:0] c, input logic [17:0] e);
    exp_t x;
    @(negedge clk);
    rst = rs; instr_valid = v; opcode = op; funct_code = fn;
    {cmp_lt, cmp_gt, cmp_eq} = fl; load_use_hazard = hz;
    #1;
    chk({tag, "_pc"}, 32'({pc_src, if_flush, pc_stall}), 32'(c));
    x.tag = tag; x.r = e;
    sb.push_back(x);
  endtask

  // Pop the expected registered word after each rising edge
  initial forever begin
    exp_t x;
    @(posedge clk); #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk({x.tag, "_ex"}, 32'({ex_valid, ex_byte_access, ex_write_back, ex_mem_write,
          ex_mem_read, ex_alu_src, ex_alu_op, ex_we1, ex_we2, ex_wd2,
          muldiv_busy, halted, illegal_op}), 32'(x.r));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    step("rst",      1, 0, 4'h0, 4'h0, 3'b000, 0, 3'b000, E0);
    step("add",      0, 1, 4'h0, 4'h0, 3'b000, 0, 3'b000, ADDW);
    step("beq_t",    0, 1, 4'h6, 4'h0, 3'b001, 0, 3'b110, E0);
    step("beq_nt",   0, 1, 4'h6, 4'h0, 3'b110, 0, 3'b000, E0);
    step("mul",      0, 1, 4'h0, 4'h4, 3'b000, 0, 3'b000, MUL_I);
    step("mul_w2",   0, 1, 4'h0, 4'h0, 3'b000, 0, 3'b001, MUL_W);
    step("mul_w1",   0, 1, 4'h0, 4'h0, 3'b000, 0, 3'b001, MUL_W);
    step("mul_w0",   0, 1, 4'h0, 4'h0, 3'b000, 0, 3'b001, MUL_F);
    step("add_md",   0, 1, 4'h0, 4'h0, 3'b000, 0, 3'b000, ADDW);
    step("blt_hz",   0, 1, 4'h4, 4'h0, 3'b100, 1, 3'b001, E0);
    step("blt_t",    0, 1, 4'h4, 4'h0, 3'b100, 0, 3'b110, E0);
    step("bgt_t",    0, 1, 4'h5, 4'h0, 3'b010, 0, 3'b110, E0);
    step("bgt_nt",   0, 1, 4'h5, 4'h0, 3'b101, 0, 3'b000, E0);
    step("jmp",      0, 1, 4'hC, 4'h0, 3'b000, 0, 3'b110, E0);
    step("div",      0, 1, 4'h0, 4'h8, 3'b000, 0, 3'b000, DIV_I);
    step("div_w2",   0, 0, 4'h0, 4'h0, 3'b000, 0, 3'b001, DIV_W);
    step("div_w1",   0, 0, 4'h0, 4'h0, 3'b000, 0, 3'b001, DIV_W);
    step("div_w0",   0, 0, 4'h0, 4'h0, 3'b000, 0, 3'b001, DIV_F);
    step("ill_op3",  0, 1, 4'h3, 4'h0, 3'b000, 0, 3'b000, ILL);
    step("lw",       0, 1, 4'hA, 4'h0, 3'b000, 0, 3'b000, LWW);
    step("lb",       0, 1, 4'h8, 4'h0, 3'b000, 0, 3'b000, LBW);
    step("sb",       0, 1, 4'h9, 4'h0, 3'b000, 0, 3'b000, SBW);
    step("sw",       0, 1, 4'hB, 4'h0, 3'b000, 0, 3'b000, SWW);
    step("andi",     0, 1, 4'h1, 4'h0, 3'b000, 0, 3'b000, ANDIW);
    step("ori",      0, 1, 4'h2, 4'h0, 3'b000, 0, 3'b000, ORIW);
    step("swap",     0, 1, 4'h0, 4'hF, 3'b000, 0, 3'b000, SWAPW);
    step("ill_f5",   0, 1, 4'h0, 4'h5, 3'b000, 0, 3'b000, ILL);
    step("idle",     0, 0, 4'h0, 4'h0, 3'b000, 0, 3'b000, E0);
    step("halt",     0, 1, 4'hF, 4'h0, 3'b000, 0, 3'b000, HLT);
    for (int i = 0; i < 3; i++)
      step("halt_add", 0, 1, 4'h0, 4'h0, 3'b000, 0, 3'b001, HLT);
    step("halt_rst", 1, 1, 4'h0, 4'h0, 3'b000, 0, 3'b001, E0);
    step("add_rst",  0, 1, 4'h0, 4'h0, 3'b000, 0, 3'b000, ADDW);
    step("mul2",     0, 1, 4'h0, 4'h4, 3'b000, 0, 3'b000, MUL_I);
    step("md_rst",   1, 1, 4'h0, 4'h1, 3'b000, 0, 3'b001, E0);
    step("sub",      0, 1, 4'h0, 4'h1, 3'b000, 0, 3'b000, SUBW);
    step("idle2",    0, 0, 4'h0, 4'h0, 3'b000, 0, 3'b000, E0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
